// File: rtl/text_console_writer.sv
// Character-terminal writer for a COLS x ROWS text VRAM: cursor, wrap, enter, backspace, prompt, scrolling by top-row rotation.
// Optional TEXT_CONSOLE_TAB_EN: 0x09 pads with spaces to the next multiple-of-8 column.
module text_console_writer #(
  parameter int unsigned COLS        = 70,
  parameter int unsigned ROWS        = 30,
  parameter logic [7:0]  PROMPT_CHAR = 8'h3E,
  parameter int unsigned PROMPT_COL  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_ascii,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [6:0] wraddr_h,
  output logic [4:0] wraddr_v,
  output logic [7:0] wrdata,
  output logic       wren,
  output logic [6:0] cur_x,
  output logic [4:0] cur_y,
  output logic [4:0] top_row,
  output logic       busy
);

  localparam logic [6:0] COLS_M1 = 7'(COLS - 1);
  localparam logic [4:0] ROWS_M1 = 5'(ROWS - 1);
  localparam logic [5:0] ROWS6   = 6'(ROWS);
  localparam logic [6:0] PCOL    = 7'(PROMPT_COL);

`ifdef TEXT_CONSOLE_TAB_EN
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_CLEAR, S_PROMPT, S_TAB} state_t;
`else
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_CLEAR, S_PROMPT} state_t;
`endif

  state_t     state;
  logic [6:0] ix;
  logic [4:0] iy;
  logic       after_prompt;

  logic [4:0] phys_cur, phys_prev, phys_bot, y_nl, top_inc;
  logic [6:0] x_inc;
  logic       scroll, is_print, accept;

  function automatic logic [4:0] phys(input logic [4:0] top, input logic [4:0] r);
    logic [5:0] s;
    s = {1'b0, top} + {1'b0, r};
    if (s >= ROWS6) s = s - ROWS6;
    return s[4:0];
  endfunction

  always_comb begin
    phys_cur  = phys(top_row, cur_y);
    phys_prev = phys(top_row, cur_y - 5'd1);
    // In CLEAR top_row has already advanced, so this is the recycled row.
    phys_bot  = phys(top_row, ROWS_M1);
    scroll    = (cur_y == ROWS_M1);
    y_nl      = scroll ? cur_y : cur_y + 5'd1;
    top_inc   = (top_row == ROWS_M1) ? '0 : top_row + 5'd1;
    x_inc     = cur_x + 7'd1;
    is_print  = (in_ascii >= 8'h20) && (in_ascii <= 8'h7E);
    accept    = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_INIT;
      ix           <= '0;
      iy           <= '0;
      after_prompt <= 1'b0;
      in_ready     <= 1'b0;
      wraddr_h     <= '0;
      wraddr_v     <= '0;
      wrdata       <= '0;
      wren         <= 1'b0;
      cur_x        <= '0;
      cur_y        <= '0;
      top_row      <= '0;
      busy         <= 1'b0;
    end else begin
      wren <= 1'b0;
      case (state)
        S_INIT: begin
          wren     <= 1'b1;
          wraddr_h <= ix;
          wraddr_v <= iy;
          wrdata   <= '0;
          cur_x    <= '0;
          cur_y    <= '0;
          top_row  <= '0;
          busy     <= 1'b1;
          in_ready <= 1'b0;
          if (ix == COLS_M1) begin
            ix <= '0;
            if (iy == ROWS_M1) begin
              iy    <= '0;
              state <= S_PROMPT;
            end else begin
              iy <= iy + 5'd1;
            end
          end else begin
            ix <= ix + 7'd1;
          end
        end

        S_PROMPT: begin
          wren     <= 1'b1;
          wraddr_h <= '0;
          wraddr_v <= phys_cur;
          wrdata   <= PROMPT_CHAR;
          cur_x    <= PCOL;
          state    <= S_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end

        S_CLEAR: begin
          wren     <= 1'b1;
          wraddr_h <= ix;
          wraddr_v <= phys_bot;
          wrdata   <= '0;
          if (ix == COLS_M1) begin
            ix <= '0;
            if (after_prompt) begin
              state <= S_PROMPT;
            end else begin
              state    <= S_IDLE;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end
          end else begin
            ix <= ix + 7'd1;
          end
        end

`ifdef TEXT_CONSOLE_TAB_EN
        S_TAB: begin
          wren     <= 1'b1;
          wraddr_h <= cur_x;
          wraddr_v <= phys_cur;
          wrdata   <= 8'h20;
          if (cur_x == COLS_M1) begin
            cur_x <= '0;
            cur_y <= y_nl;
            if (scroll) begin
              top_row      <= top_inc;
              after_prompt <= 1'b0;
              state        <= S_CLEAR;
            end else begin
              state    <= S_IDLE;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end
          end else begin
            cur_x <= x_inc;
            if (x_inc[2:0] == 3'd0) begin
              state    <= S_IDLE;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end
`endif

        S_IDLE: begin
          if (accept) begin
            if (is_print) begin
              wren     <= 1'b1;
              wraddr_h <= cur_x;
              wraddr_v <= phys_cur;
              wrdata   <= in_ascii;
              if (cur_x == COLS_M1) begin
                cur_x <= '0;
                cur_y <= y_nl;
                if (scroll) begin
                  top_row      <= top_inc;
                  after_prompt <= 1'b0;
                  state        <= S_CLEAR;
                  in_ready     <= 1'b0;
                  busy         <= 1'b1;
                end
              end else begin
                cur_x <= x_inc;
              end
            end else if (in_ascii == 8'h0D) begin
              cur_x    <= '0;
              cur_y    <= y_nl;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              if (scroll) begin
                top_row      <= top_inc;
                after_prompt <= 1'b1;
                state        <= S_CLEAR;
              end else begin
                state <= S_PROMPT;
              end
            end else if (in_ascii == 8'h08) begin
              if (cur_x != '0) begin
                cur_x    <= cur_x - 7'd1;
                wren     <= 1'b1;
                wraddr_h <= cur_x - 7'd1;
                wraddr_v <= phys_cur;
                wrdata   <= '0;
              end else if (cur_y != '0) begin
                cur_y    <= cur_y - 5'd1;
                cur_x    <= COLS_M1;
                wren     <= 1'b1;
                wraddr_h <= COLS_M1;
                wraddr_v <= phys_prev;
                wrdata   <= '0;
              end
`ifdef TEXT_CONSOLE_TAB_EN
            end else if (in_ascii == 8'h09) begin
              state    <= S_TAB;
              in_ready <= 1'b0;
              busy     <= 1'b1;
`endif
            end
          end
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule
